iir_sos_cascade: RTL and testbench

IIR_SOS_CASCADE -- requirements
Module: iir_sos_cascade

---
 rtl/iir_sos_cascade.sv | 214 +++++++++++++++++++++
 tb/tb_iir_sos_cascade.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_sos_cascade.sv
// iir_sos_cascade: cascade of SECTIONS direct-form-I biquads that share one
// signed WORD_SIZE x WORD_SIZE multiplier. Each sample takes 5 MAC cycles per
// section (b0, b1, b2, a1, a2) plus one drain cycle before it is presented.
// Optional feature macro: IIR_SOS_SAT_EN makes section results saturate
// instead of wrapping.
`timescale 1ns/1ps
module iir_sos_cascade #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned FRAC_BIT  = 24,
  parameter int unsigned SECTIONS  = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [WORD_SIZE-1:0]                 in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [WORD_SIZE-1:0]                 out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  input  logic                                 coef_we,
  input  logic [$clog2(5*SECTIONS)-1:0]        coef_addr,
  input  logic [WORD_SIZE-1:0]                 coef_data,
  output logic                                 coef_err
);

  localparam int unsigned ADDR_W = $clog2(5*SECTIONS);
  localparam int unsigned ACC_W  = 2*WORD_SIZE + 4;
  localparam int unsigned PROD_W = 2*WORD_SIZE;
  localparam int unsigned N_COEF = 5*SECTIONS;
  localparam int unsigned SEC_W  = $clog2(SECTIONS + 1);
  localparam int unsigned SIDX_W = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic signed [WORD_SIZE-1:0] r_coef [N_COEF];
  logic signed [WORD_SIZE-1:0] r_x1   [SECTIONS];
  logic signed [WORD_SIZE-1:0] r_x2   [SECTIONS];
  logic signed [WORD_SIZE-1:0] r_y1   [SECTIONS];
  logic signed [WORD_SIZE-1:0] r_y2   [SECTIONS];

  logic signed [WORD_SIZE-1:0] r_x;
  logic signed [ACC_W-1:0]     r_acc;
  logic [2:0]                  r_k;
  logic [SEC_W-1:0]            r_sec;
  logic [WORD_SIZE-1:0]        r_out_data;
  logic                        r_coef_err;

  logic                        w_coef_ok;
  logic                        w_mac_sec;
  logic                        w_drain;
  logic                        w_sec_done;
  logic [SIDX_W-1:0]           w_sidx;
  logic [ADDR_W-1:0]           w_cidx;
  logic signed [WORD_SIZE-1:0] w_coef;
  logic signed [WORD_SIZE-1:0] w_opd;
  logic signed [PROD_W-1:0]    w_prod;
  logic signed [ACC_W-1:0]     w_prod_ext;
  logic signed [ACC_W-1:0]     w_acc_base;
  logic signed [ACC_W-1:0]     w_acc_next;
  logic signed [WORD_SIZE-1:0] w_result;

  // Write accepted only while idle and inside the coefficient table.
  assign w_coef_ok  = coef_we && (r_state == IDLE) && (32'(coef_addr) < N_COEF);
  assign w_mac_sec  = (r_state == MAC) && (32'(r_sec) < SECTIONS);
  assign w_drain    = (r_state == MAC) && !w_mac_sec;
  assign w_sec_done = w_mac_sec && (r_k == 3'd4);
  assign w_sidx     = SIDX_W'(r_sec);
  assign w_cidx     = w_mac_sec ? ADDR_W'(32'(r_sec) * 32'd5 + 32'(r_k)) : '0;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == OUTPUT);
  assign out_data  = r_out_data;
  assign coef_err  = r_coef_err;

  // Operand selection for the current tap of the active section.
  always_comb begin
    w_opd = r_x;
    case (r_k)
      3'd0:    w_opd = r_x;
      3'd1:    w_opd = r_x1[w_sidx];
      3'd2:    w_opd = r_x2[w_sidx];
      3'd3:    w_opd = r_y1[w_sidx];
      default: w_opd = r_y2[w_sidx];
    endcase
  end

  // Shared multiplier and accumulator; accumulator restarts at tap b0, feedback taps subtract.
  always_comb begin
    w_coef     = r_coef[w_cidx];
    w_prod     = PROD_W'(w_coef) * PROD_W'(w_opd);
    w_prod_ext = ACC_W'(w_prod);
    w_acc_base = (r_k == 3'd0) ? '0 : r_acc;
    w_acc_next = (r_k >= 3'd3) ? (w_acc_base - w_prod_ext) : (w_acc_base + w_prod_ext);
  end

`ifdef IIR_SOS_SAT_EN
  logic signed [ACC_W-1:0]       w_shift;
  logic [ACC_W-WORD_SIZE:0]      w_hi;

  // Floor-shift back to sample scale, clamping out-of-range results.
  always_comb begin
    w_shift = w_acc_next >>> FRAC_BIT;
    w_hi    = w_shift[ACC_W-1:WORD_SIZE-1];
    if ((&w_hi) || !(|w_hi)) begin
      w_result = w_shift[WORD_SIZE-1:0];
    end else if (w_shift[ACC_W-1]) begin
      w_result = {1'b1, {(WORD_SIZE-1){1'b0}}};
    end else begin
      w_result = {1'b0, {(WORD_SIZE-1){1'b1}}};
    end
  end
`else
  // Floor-shift back to sample scale, keeping the low bits (wrap).
  always_comb begin
    w_result = WORD_SIZE'(w_acc_next >>> FRAC_BIT);
  end
`endif

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = MAC;
      MAC:     if (w_drain) w_state_next = OUTPUT;
      OUTPUT:  if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Coefficient table and rejected-write flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_COEF; i++) begin
        r_coef[i] <= '0;
      end
      r_coef_err <= 1'b0;
    end else begin
      r_coef_err <= coef_we && !w_coef_ok;
      if (w_coef_ok) begin
        r_coef[coef_addr] <= coef_data;
      end
    end
  end

  // Per-section delay lines, shifted when a section finishes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SECTIONS; i++) begin
        r_x1[i] <= '0;
        r_x2[i] <= '0;
        r_y1[i] <= '0;
        r_y2[i] <= '0;
      end
    end else if (w_sec_done) begin
      r_x2[w_sidx] <= r_x1[w_sidx];
      r_x1[w_sidx] <= r_x;
      r_y2[w_sidx] <= r_y1[w_sidx];
      r_y1[w_sidx] <= w_result;
    end
  end

  // Sample capture, tap/section sequencing and output register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_x        <= '0;
      r_acc      <= '0;
      r_k        <= '0;
      r_sec      <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x   <= in_data;
            r_k   <= '0;
            r_sec <= '0;
          end
        end
        MAC: begin
          if (w_drain) begin
            r_out_data <= r_x;
          end else begin
            r_acc <= w_acc_next;
            if (r_k == 3'd4) begin
              r_x   <= w_result;
              r_k   <= '0;
              r_sec <= r_sec + SEC_W'(1);
            end else begin
              r_k <= r_k + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_sos_cascade.sv
// Bench for iir_sos_cascade (WORD_SIZE=32, FRAC_BIT=24, SECTIONS=2).
// A sample-level biquad model predicts every output; a per-cycle compare
// process checks handshake timing and data, and directed literals pin the model.
`timescale 1ns/1ps
module tb_iir_sos_cascade;

  localparam int unsigned NC  = 10;
  localparam int          LAT = 11;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [31:0] coef_data = '0;
  logic        coef_err;

  int checks = 0;
  int failures = 0;

  iir_sos_cascade #(.WORD_SIZE(32), .FRAC_BIT(24), .SECTIONS(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_err  (coef_err)
  );

  always #5 clock = ~clock;

  // ---------------- model ----------------
  logic signed [31:0] m_coef [NC];
  logic signed [31:0] m_x1 [2];
  logic signed [31:0] m_x2 [2];
  logic signed [31:0] m_y1 [2];
  logic signed [31:0] m_y2 [2];
  logic [31:0]        m_q [$];
  bit                 m_busy = 1'b0;
  int                 m_cnt = 0;
  bit                 m_err = 1'b0;

  function automatic logic [31:0] model_run(input logic [31:0] xin);
    logic signed [67:0] acc;
    logic signed [67:0] sh;
    logic signed [31:0] x;
    logic signed [31:0] y;
    x = xin;
    for (int s = 0; s < 2; s++) begin
      acc = 68'(m_coef[s*5+0]) * 68'(x)
          + 68'(m_coef[s*5+1]) * 68'(m_x1[s])
          + 68'(m_coef[s*5+2]) * 68'(m_x2[s])
          - 68'(m_coef[s*5+3]) * 68'(m_y1[s])
          - 68'(m_coef[s*5+4]) * 68'(m_y2[s]);
      sh = acc >>> 24;
`ifdef IIR_SOS_SAT_EN
      if (sh > 68'sh7FFFFFFF) y = 32'sh7FFFFFFF;
      else if (sh < -68'sh80000000) y = 32'sh80000000;
      else y = sh[31:0];
`else
      y = sh[31:0];
`endif
      m_x2[s] = m_x1[s];
      m_x1[s] = x;
      m_y2[s] = m_y1[s];
      m_y1[s] = y;
      x = y;
    end
    return x;
  endfunction

  // Model update at each rising edge: coefficient writes first, then handshakes.
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 10; i++) m_coef[i] = '0;
      for (int s = 0; s < 2; s++) begin
        m_x1[s] = '0; m_x2[s] = '0; m_y1[s] = '0; m_y2[s] = '0;
      end
      m_q.delete();
      m_busy = 1'b0;
      m_cnt  = 0;
      m_err  = 1'b0;
    end else begin
      m_err = coef_we && (m_busy || coef_addr >= 4'd10);
      if (coef_we && !m_busy && coef_addr < 4'd10) m_coef[coef_addr] = coef_data;
      if (m_busy) begin
        if (m_cnt >= LAT && out_ready) begin
          m_busy = 1'b0;
          void'(m_q.pop_front());
        end else begin
          m_cnt++;
        end
      end else if (in_valid) begin
        m_q.push_back(model_run(in_data));
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  logic c_exp_v;
  always @(negedge clock) begin
    if (reset) begin
      c_exp_v = m_busy && (m_cnt >= LAT);
      chk("cmp_in_ready", 32'(in_ready), 32'(!m_busy));
      chk("cmp_out_valid", 32'(out_valid), 32'(c_exp_v));
      chk("cmp_coef_err", 32'(coef_err), 32'(m_err));
      if (c_exp_v && m_q.size() > 0) chk("cmp_out_data", out_data, m_q[0]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wr_coef(input logic [3:0] a, input logic [31:0] d, input logic exp_err, input string nm);
    @(negedge clock);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(negedge clock);
    coef_we = 1'b0;
    chk(nm, 32'(coef_err), 32'(exp_err));
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic collect(input logic [31:0] exp, input string nm);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!out_valid) begin
      chk({nm, "_timeout"}, 32'(out_valid), 32'd1);
    end else begin
      chk(nm, out_data, exp);
    end
    @(negedge clock);
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] exp, input string nm);
    int n;
    int lat;
    @(negedge clock);
    in_valid = 1'b1; in_data = d;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      chk({nm, "_ready_timeout"}, 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    chk({nm, "_latency"}, 32'(lat), 32'(LAT));
    chk(nm, out_data, exp);
    @(negedge clock);
  endtask

  initial begin
    int pulses;
    int nv;
    repeat (2) @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_coef_err", 32'(coef_err), 32'd0);
    #1 reset = 1'b1;

    // Passthrough
    wr_coef(4'd0, 32'h01000000, 1'b0, "wr_s0_b0");
    wr_coef(4'd5, 32'h01000000, 1'b0, "wr_s1_b0");
    send(32'h12345678, 32'h12345678, "passthrough");

    // Feedback impulse response
    do_reset();
    wr_coef(4'd0, 32'h01000000, 1'b0, "wr_s0_b0");
    wr_coef(4'd5, 32'h01000000, 1'b0, "wr_s1_b0");
    wr_coef(4'd3, 32'hFF800000, 1'b0, "wr_s0_a1");
    send(32'h01000000, 32'h01000000, "impulse_0");
    send(32'h00000000, 32'h00800000, "impulse_1");
    send(32'h00000000, 32'h00400000, "impulse_2");
    send(32'h00000000, 32'h00200000, "impulse_3");

    // Overflow
    do_reset();
    wr_coef(4'd0, 32'h04000000, 1'b0, "wr_s0_b0_x4");
    wr_coef(4'd5, 32'h01000000, 1'b0, "wr_s1_b0");
`ifdef IIR_SOS_SAT_EN
    send(32'h7FFFFFFF, 32'h7FFFFFFF, "overflow_sat");
`else
    send(32'h7FFFFFFF, 32'hFFFFFFFC, "overflow_wrap");
`endif

    // Backpressure and coefficient guard
    do_reset();
    wr_coef(4'd0, 32'h01000000, 1'b0, "wr_s0_b0");
    wr_coef(4'd5, 32'h01000000, 1'b0, "wr_s1_b0");
    @(negedge clock);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h00ABCDEF;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 32'h02000000;
    @(negedge clock);
    coef_we = 1'b0;
    pulses = 0;
    repeat (4) begin
      if (coef_err) pulses++;
      @(negedge clock);
    end
    chk("mac_write_err_pulses", 32'(pulses), 32'd1);
    nv = 0;
    while (!out_valid && nv < 100) begin
      @(negedge clock);
      nv++;
    end
    chk("bp_first_valid", 32'(out_valid), 32'd1);
    repeat (10) begin
      chk("bp_data_stable", out_data, 32'h00ABCDEF);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_released_idle", 32'(in_ready), 32'd1);
    send(32'h00000200, 32'h00000200, "coef_unchanged");

    // Write and handshake in the same idle cycle: sample sees the new b0
    @(negedge clock);
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 32'h02000000;
    in_valid = 1'b1; in_data = 32'h00000100;
    @(posedge clock);
    @(negedge clock);
    coef_we = 1'b0; in_valid = 1'b0;
    collect(32'h00000200, "same_cycle_write");

    // Out-of-range addresses are rejected, last legal address accepted
    wr_coef(4'd10, 32'h7FFFFFFF, 1'b1, "oor_addr_10");
    wr_coef(4'd15, 32'h7FFFFFFF, 1'b1, "oor_addr_15");
    wr_coef(4'd9, 32'h00000000, 1'b0, "inrange_addr_9");
    send(32'h00000300, 32'h00000600, "gain2_after_oor");

    // Reset on MAC cycle 3 abandons the sample and clears state
    wr_coef(4'd3, 32'hFF800000, 1'b0, "wr_s0_a1");
    @(negedge clock);
    in_valid = 1'b1; in_data = 32'h00005555;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    #1 reset = 1'b1;
    nv = 0;
    repeat (20) begin
      @(negedge clock);
      if (out_valid) nv++;
    end
    chk("abandoned_no_valid", 32'(nv), 32'd0);
    send(32'h00001234, 32'h00000000, "coef_cleared");
    wr_coef(4'd0, 32'h01000000, 1'b0, "wr_s0_b0");
    wr_coef(4'd5, 32'h01000000, 1'b0, "wr_s1_b0");
    wr_coef(4'd3, 32'hFF800000, 1'b0, "wr_s0_a1");
    send(32'h00000100, 32'h00000100, "post_reset_pass");
    send(32'h00000000, 32'h00000080, "post_reset_decay");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
